// File: rtl/port_pkg.sv
// Shared definitions for the port toggle bank: port state encoding and synchroniser depth.
// No logic; constants and types only.
// Imported by port_debounce and port_toggle_bank.
package port_pkg;

  localparam logic PORT_CLOSED = 1'b0;
  localparam logic PORT_OPEN   = 1'b1;

  // Depth of the metastability synchroniser on each raw switch input
  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    ST_CLOSED = PORT_CLOSED,
    ST_OPEN   = PORT_OPEN
  } port_state_t;

endpackage

// File: rtl/port_debounce.sv
// Single-channel switch conditioner: 2-flop synchroniser, stable-count debounce, press pulse.
// Latency: a clean rising level yields press one cycle after SYNC_STAGES+DEBOUNCE_CYCLES-1 edges.
// No backpressure; press is a one-cycle registered pulse.
module port_debounce
  import port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic [CW-1:0]          cnt;
  logic                   db;
  logic                   armed;
  logic                   lvl;

  assign lvl = sync[SYNC_STAGES-1];

  // Synchroniser chain plus a fill marker so reset-cleared stages are not mistaken for a real low level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      sync_vld <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], sw};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Debounce counter; a press needs a genuine low seen after reset so a switch held through reset is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      db    <= 1'b0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_vld[SYNC_STAGES-1] && !lvl) begin
        armed <= 1'b1;
      end
      if (lvl != db) begin
        if (cnt == CNT_LAST) begin
          db    <= lvl;
          cnt   <= '0;
          press <= lvl & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/port_toggle_bank.sv
// Bank of N open/close port controllers toggled by debounced switch presses, with interlock and auto-close.
// Latency: switch stable high from edge k changes OpenClose at edge k+DEBOUNCE_CYCLES+2; outputs registered.
// No backpressure; requests while Enable=0 are dropped, refused opens pulse Denied for one cycle.
module port_toggle_bank
  import port_pkg::*;
#(
  parameter int N_PORTS           = 2,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int AUTO_CLOSE_CYCLES = 0,
  parameter int INTERLOCK         = 1,
  parameter int TIMER_W           = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [N_PORTS-1:0] SwitchFlip,
  input  logic               Enable,
  output logic [N_PORTS-1:0] OpenClose,
  output logic [N_PORTS-1:0] Denied,
  output logic               AnyOpen
);

  localparam logic [TIMER_W-1:0] TO_LAST =
    TIMER_W'((AUTO_CLOSE_CYCLES > 0) ? AUTO_CLOSE_CYCLES - 1 : 0);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] timeout;
  logic [N_PORTS-1:0] closing;
  logic [N_PORTS-1:0] open_go;
  logic [N_PORTS-1:0] deny;
  logic [N_PORTS-1:0] open_nxt;
  logic               busy;
  port_state_t        state     [N_PORTS];
  port_state_t        state_nxt [N_PORTS];
  logic [TIMER_W-1:0] timer     [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_db
    port_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (Clock),
      .rst  (Reset),
      .sw   (SwitchFlip[g]),
      .press(req[g])
    );
  end

  // Arbitration: closers free the slot this edge; the lowest-index opener takes it, later openers are denied
  always_comb begin
    timeout  = '0;
    closing  = '0;
    open_go  = '0;
    deny     = '0;
    open_nxt = '0;
    busy     = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      state_nxt[i] = state[i];
      timeout[i]   = (AUTO_CLOSE_CYCLES != 0) && (timer[i] == TO_LAST);
      closing[i]   = (state[i] == ST_OPEN) && ((req[i] && Enable) || timeout[i]);
      if (state[i] == ST_OPEN && !closing[i]) begin
        busy = 1'b1;
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (state[i] == ST_CLOSED && req[i] && Enable) begin
        if (INTERLOCK != 0 && busy) begin
          deny[i] = 1'b1;
        end else begin
          open_go[i] = 1'b1;
          if (INTERLOCK != 0) begin
            busy = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (open_go[i]) begin
        state_nxt[i] = ST_OPEN;
      end else if (closing[i]) begin
        state_nxt[i] = ST_CLOSED;
      end
      open_nxt[i] = (state_nxt[i] == ST_OPEN);
    end
  end

  // Per-channel FSM state and registered outputs, all taken from next-state so they stay aligned
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        state[i] <= ST_CLOSED;
      end
      OpenClose <= '0;
      Denied    <= '0;
      AnyOpen   <= 1'b0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        state[i] <= state_nxt[i];
      end
      OpenClose <= open_nxt;
      Denied    <= deny;
      AnyOpen   <= |open_nxt;
    end
  end

  // Auto-close timers: load on open, count while open, saturate, held at zero when closed or disabled
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (open_go[i] || !open_nxt[i] || AUTO_CLOSE_CYCLES == 0) begin
          timer[i] <= '0;
        end else if (timer[i] != {TIMER_W{1'b1}}) begin
          timer[i] <= timer[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_port_toggle_bank.sv
// Self-checking bench for port_toggle_bank: directed scenarios plus random switch activity.
// Every cycle the outputs are compared against a behavioural model built from the port rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_port_toggle_bank;

  localparam int N  = 2;
  localparam int DC = 4;
  localparam int AC = 20;
  localparam int IL = 1;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Enable = 1'b1;
  logic [N-1:0] SwitchFlip = '0;
  logic [N-1:0] OpenClose;
  logic [N-1:0] Denied;
  logic         AnyOpen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  port_toggle_bank #(
    .N_PORTS(N), .DEBOUNCE_CYCLES(DC), .AUTO_CLOSE_CYCLES(AC),
    .INTERLOCK(IL), .TIMER_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SwitchFlip(SwitchFlip), .Enable(Enable),
    .OpenClose(OpenClose), .Denied(Denied), .AnyOpen(AnyOpen)
  );

  // Reference model. Pipe slots hold -1 for "cleared by reset", else the sampled raw level.
  int           p1 [N];
  int           p2 [N];
  bit           db [N];
  bit           armed [N];
  bit           pend [N];
  bit           mopen [N];
  int           age [N];
  bit           win [N][$];
  logic [N-1:0] exp_oc  = '0;
  logic [N-1:0] exp_den = '0;
  logic         exp_any = 1'b0;

  always @(posedge Clock) begin : model
    bit busy;
    bit closing [N];
    bit opening [N];
    bit lvl;
    bit all_diff;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        p1[i] = -1; p2[i] = -1; db[i] = 0; armed[i] = 0; pend[i] = 0;
        mopen[i] = 0; age[i] = 0; win[i].delete();
      end
      exp_den = '0;
    end else begin
      busy = 0;
      for (int i = 0; i < N; i++) begin
        closing[i] = mopen[i] && ((pend[i] && Enable) || (AC != 0 && age[i] == AC));
        opening[i] = 0;
        if (mopen[i] && !closing[i]) busy = 1;
      end
      exp_den = '0;
      for (int i = 0; i < N; i++) begin
        if (!mopen[i] && pend[i] && Enable) begin
          if (IL != 0 && busy) exp_den[i] = 1'b1;
          else begin
            opening[i] = 1;
            if (IL != 0) busy = 1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (opening[i]) begin mopen[i] = 1; age[i] = 1; end
        else if (closing[i]) begin mopen[i] = 0; age[i] = 0; end
        else if (mopen[i]) age[i] = age[i] + 1;
      end
      // Debounce: the level flips once DC consecutive observed samples all disagree with it
      for (int i = 0; i < N; i++) begin
        lvl = (p2[i] == 1);
        pend[i] = 0;
        win[i].push_back(lvl);
        if (win[i].size() > DC) void'(win[i].pop_front());
        if (win[i].size() == DC) begin
          all_diff = 1;
          foreach (win[i][k]) if (win[i][k] == db[i]) all_diff = 0;
          if (all_diff) begin
            db[i] = !db[i];
            if (db[i] && armed[i]) pend[i] = 1;
            win[i].delete();
          end
        end
        if (p2[i] == 0) armed[i] = 1;
        p2[i] = p1[i];
        p1[i] = SwitchFlip[i] ? 1 : 0;
      end
    end
    for (int i = 0; i < N; i++) exp_oc[i] = mopen[i];
    exp_any = |exp_oc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
    chk("oc_vs_model", 32'(OpenClose), 32'(exp_oc));
    chk("denied_vs_model", 32'(Denied), 32'(exp_den));
    chk("anyopen_vs_model", 32'(AnyOpen), 32'(exp_any));
    chk("at_most_one_open", 32'($countones(OpenClose) <= 1), 32'd1);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // Reset state
    cycn(2);
    chk("reset_oc", 32'(OpenClose), 32'd0);
    chk("reset_denied", 32'(Denied), 32'd0);
    chk("reset_anyopen", 32'(AnyOpen), 32'd0);
    Reset = 1'b0;
    cycn(4);

    // First press: opens exactly 6 edges after the first sampled-high edge
    SwitchFlip = 2'b01;
    cycn(6);
    chk("press_before_latency", 32'(OpenClose), 32'd0);
    cyc();
    chk("press_open", 32'(OpenClose), 32'b01);
    chk("press_anyopen", 32'(AnyOpen), 32'd1);
    cycn(3);
    SwitchFlip = 2'b00;
    cycn(6);
    // Second press toggles it closed
    SwitchFlip = 2'b01;
    cycn(6);
    chk("toggle_still_open", 32'(OpenClose), 32'b01);
    cyc();
    chk("toggle_closed", 32'(OpenClose), 32'd0);
    SwitchFlip = 2'b00;
    cycn(10);

    // Glitch of 3 cycles is ignored
    SwitchFlip = 2'b10;
    cycn(3);
    SwitchFlip = 2'b00;
    cycn(10);
    chk("glitch_ignored", 32'(OpenClose), 32'd0);

    // Interlock: second port refused while the first is open
    SwitchFlip = 2'b01;
    cycn(7);
    chk("il_port0_open", 32'(OpenClose), 32'b01);
    SwitchFlip = 2'b11;
    cycn(6);
    chk("il_no_early_deny", 32'(Denied), 32'd0);
    cyc();
    chk("il_denied", 32'(Denied), 32'b10);
    chk("il_oc_kept", 32'(OpenClose), 32'b01);
    cyc();
    chk("il_deny_one_cycle", 32'(Denied), 32'd0);
    SwitchFlip = 2'b00;
    cycn(14);
    chk("il_port0_autoclosed", 32'(OpenClose), 32'd0);
    cycn(4);
    // Simultaneous presses: lowest index wins
    SwitchFlip = 2'b11;
    cycn(7);
    chk("simul_oc", 32'(OpenClose), 32'b01);
    chk("simul_denied", 32'(Denied), 32'b10);
    SwitchFlip = 2'b00;
    cycn(25);
    chk("simul_closed", 32'(OpenClose), 32'd0);

    // Auto-close: open for exactly AC cycles
    SwitchFlip = 2'b10;
    cycn(7);
    chk("ac_open", 32'(OpenClose), 32'b10);
    for (int i = 0; i < AC - 1; i++) begin
      cyc();
      if (i == 2) SwitchFlip = 2'b00;
      chk("ac_held_open", 32'(OpenClose), 32'b10);
    end
    cyc();
    chk("ac_closed", 32'(OpenClose), 32'd0);
    cycn(6);
    // Press landing on the timeout edge closes once, no reopen
    SwitchFlip = 2'b10;
    cycn(4);
    SwitchFlip = 2'b00;
    cycn(3);
    chk("act_open", 32'(OpenClose), 32'b10);
    cycn(13);
    SwitchFlip = 2'b10;
    cycn(6);
    chk("act_before_timeout", 32'(OpenClose), 32'b10);
    cyc();
    chk("act_closed", 32'(OpenClose), 32'd0);
    chk("act_no_deny", 32'(Denied), 32'd0);
    cycn(20);
    chk("act_no_reopen", 32'(OpenClose), 32'd0);
    SwitchFlip = 2'b00;
    cycn(10);

    // Reset mid-operation with switches held
    SwitchFlip = 2'b01;
    cycn(7);
    chk("rst_pre_open", 32'(OpenClose), 32'b01);
    SwitchFlip = 2'b11;
    cycn(2);
    Reset = 1'b1;
    cyc();
    chk("rst_mid_oc", 32'(OpenClose), 32'd0);
    chk("rst_mid_anyopen", 32'(AnyOpen), 32'd0);
    Reset = 1'b0;
    cycn(15);
    chk("rst_held_no_reopen", 32'(OpenClose), 32'd0);
    SwitchFlip = 2'b00;
    cycn(10);
    SwitchFlip = 2'b01;
    cycn(6);
    chk("rst_repress_wait", 32'(OpenClose), 32'd0);
    cyc();
    chk("rst_repress_open", 32'(OpenClose), 32'b01);
    SwitchFlip = 2'b00;
    cycn(25);

    // Enable low drops requests
    Enable = 1'b0;
    SwitchFlip = 2'b10;
    cycn(10);
    chk("disabled_no_open", 32'(OpenClose), 32'd0);
    chk("disabled_no_deny", 32'(Denied), 32'd0);
    SwitchFlip = 2'b00;
    cycn(8);
    Enable = 1'b1;

    // Random switch activity checked against the model
    for (int k = 0; k < 80; k++) begin
      SwitchFlip = N'($urandom_range(0, 3));
      Enable = ($urandom_range(0, 7) != 0);
      Reset = ($urandom_range(0, 40) == 0);
      cycn($urandom_range(1, 12));
    end
    Reset = 1'b0;
    Enable = 1'b1;
    cycn(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
